// File: rtl/dram_controller_if.sv
// CPU-side bus bundle for the FPM DRAM controller: bus cycle qualifiers in,
// DRAM strobes, multiplexed address and DTACK out.
interface dram_controller_if #(
    parameter int unsigned ROW_BITS = 10,
    parameter int unsigned COL_BITS = 10
);
    logic                         CS_DRAM_n;
    logic                         AS_n;
    logic                         UDS_n;
    logic                         LDS_n;
    logic                         RW;
    logic [ROW_BITS+COL_BITS-1:0] ADDR;
    logic                         DTACK_DRAM_n;
    logic                         RAS_n;
    logic                         CASU_n;
    logic                         CASL_n;
    logic                         WE_n;
    logic [ROW_BITS-1:0]          MA;

    modport master (
        output CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
        input  DTACK_DRAM_n, RAS_n, CASU_n, CASL_n, WE_n, MA
    );

    modport slave (
        input  CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
        output DTACK_DRAM_n, RAS_n, CASU_n, CASL_n, WE_n, MA
    );
endinterface

// File: rtl/dram_controller.sv
// FPM DRAM controller: row/column multiplexing, per-byte CAS, registered strobes
// and periodic CAS-before-RAS refresh that takes priority over CPU accesses.
module dram_controller #(
    parameter int unsigned ROW_BITS         = 10,
    parameter int unsigned COL_BITS         = 10,
    parameter int unsigned REFRESH_CYCLES   = 156,
    parameter int unsigned RAS_CYCLES       = 2,
    parameter int unsigned PRECHARGE_CYCLES = 2
) (
    input logic              CLK_CPU,
    input logic              RST_n,
    dram_controller_if.slave bus
);

    localparam int unsigned RcW  = $clog2(REFRESH_CYCLES + 1);
    localparam int unsigned CntW = $clog2((RAS_CYCLES > PRECHARGE_CYCLES ?
                                           RAS_CYCLES : PRECHARGE_CYCLES) + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StRow, StCol, StHold, StRefCas, StRefRas, StPre
    } state_e;

    state_e              state_q, state_d;
    logic [RcW-1:0]      ref_cnt_q, ref_cnt_d;
    logic                ref_pend_q, ref_pend_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ras_q, ras_d;
    logic                casu_q, casu_d;
    logic                casl_q, casl_d;
    logic                we_q, we_d;
    logic                dtack_q, dtack_d;
    logic [ROW_BITS-1:0] ma_q, ma_d;
    logic                req;
    logic                wrap;

    assign req  = !bus.CS_DRAM_n && !bus.AS_n;
    assign wrap = (ref_cnt_q == RcW'(REFRESH_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = wrap ? '0 : ref_cnt_q + 1'b1;
        ref_pend_d = ref_pend_q | wrap;
        cnt_d      = cnt_q;
        ras_d      = ras_q;
        casu_d     = casu_q;
        casl_d     = casl_q;
        we_d       = we_q;
        dtack_d    = dtack_q;
        ma_d       = ma_q;

        case (state_q)
            StIdle: begin
                // The wrap edge itself already counts as a pending refresh.
                if (ref_pend_q || wrap) begin
                    state_d    = StRefCas;
                    ref_pend_d = 1'b0;
                end else if (req) begin
                    state_d = StRow;
                    ma_d    = bus.ADDR[ROW_BITS+COL_BITS-1:COL_BITS];
                    ras_d   = 1'b0;
                end
            end
            StRow: begin
                if (bus.AS_n) begin
                    {ras_d, casu_d, casl_d, we_d, dtack_d} = '1;
                    cnt_d   = '0;
                    state_d = StPre;
                end else begin
                    ma_d    = ROW_BITS'(bus.ADDR[COL_BITS-1:0]);
                    we_d    = bus.RW;
                    state_d = StCol;
                end
            end
            StCol: begin
                if (bus.AS_n) begin
                    {ras_d, casu_d, casl_d, we_d, dtack_d} = '1;
                    cnt_d   = '0;
                    state_d = StPre;
                end else if (!(bus.UDS_n && bus.LDS_n)) begin
                    casu_d  = bus.UDS_n;
                    casl_d  = bus.LDS_n;
                    dtack_d = 1'b0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.AS_n) begin
                    {ras_d, casu_d, casl_d, we_d, dtack_d} = '1;
                    cnt_d   = '0;
                    state_d = StPre;
                end
            end
            StRefCas: begin
                casu_d  = 1'b0;
                casl_d  = 1'b0;
                cnt_d   = '0;
                state_d = StRefRas;
            end
            StRefRas: begin
                // First edge drops RAS; it is released after RAS_CYCLES more edges.
                if (cnt_q == CntW'(RAS_CYCLES)) begin
                    {ras_d, casu_d, casl_d, we_d, dtack_d} = '1;
                    cnt_d   = '0;
                    state_d = StPre;
                end else begin
                    ras_d = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPre: begin
                if (cnt_q == CntW'(PRECHARGE_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                {ras_d, casu_d, casl_d, we_d, dtack_d} = '1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK_CPU) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            cnt_q      <= '0;
            ras_q      <= 1'b1;
            casu_q     <= 1'b1;
            casl_q     <= 1'b1;
            we_q       <= 1'b1;
            dtack_q    <= 1'b1;
            ma_q       <= '0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            cnt_q      <= cnt_d;
            ras_q      <= ras_d;
            casu_q     <= casu_d;
            casl_q     <= casl_d;
            we_q       <= we_d;
            dtack_q    <= dtack_d;
            ma_q       <= ma_d;
        end
    end

    assign bus.RAS_n        = ras_q;
    assign bus.CASU_n       = casu_q;
    assign bus.CASL_n       = casl_q;
    assign bus.WE_n         = we_q;
    assign bus.DTACK_DRAM_n = dtack_q;
    assign bus.MA           = ma_q;

endmodule

// File: tb/tb_dram_controller.sv
// Scoreboard bench for dram_controller: stimulus queues expected row/ack/release and
// refresh events with cycle stamps; a negedge monitor detects strobe edges and compares.
module tb_dram_controller;

    localparam int REF_C = 156;
    localparam int RAS_C = 2;
    localparam int PRE_C = 2;
    localparam int KRow  = 0;
    localparam int KAck  = 1;
    localparam int KRel  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [9:0] ma;
        logic       u;
        logic       l;
        logic       we;
    } exp_t;

    logic CLK_CPU = 1'b0;
    logic RST_n;
    logic rst_edge = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t acc_q[$];
    int   ref_q[$];

    dram_controller_if #(.ROW_BITS(10), .COL_BITS(10)) bus ();

    dram_controller #(
        .ROW_BITS(10), .COL_BITS(10), .REFRESH_CYCLES(REF_C),
        .RAS_CYCLES(RAS_C), .PRECHARGE_CYCLES(PRE_C)
    ) dut (
        .CLK_CPU(CLK_CPU),
        .RST_n  (RST_n),
        .bus    (bus)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    always @(posedge CLK_CPU) begin
        cyc      <= cyc + 1;
        rst_edge <= RST_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, want, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [9:0] ma,
                        input logic u, input logic l, input logic we);
        exp_t e;
        e.kind = kind; e.cyc = c; e.ma = ma; e.u = u; e.l = l; e.we = we;
        acc_q.push_back(e);
    endtask

    task automatic pop_acc(input int kind);
        exp_t e;
        if (acc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL acc_unexpected kind=%0d cyc=%0d required=none", kind, cyc);
        end else begin
            e = acc_q.pop_front();
            chk("acc_kind", kind, e.kind);
            chk("acc_cyc", cyc, e.cyc);
            if (kind == KRow) chk("row_ma", bus.MA, e.ma);
            if (kind == KAck) begin
                chk("ack_col_ma", bus.MA, e.ma);
                chk("ack_casu", bus.CASU_n, e.u);
                chk("ack_casl", bus.CASL_n, e.l);
                chk("ack_we", bus.WE_n, e.we);
                chk("ack_ras", bus.RAS_n, 1'b0);
            end
            if (kind == KRel)
                chk("rel_strobes", {bus.DTACK_DRAM_n, bus.CASU_n, bus.CASL_n, bus.WE_n}, 4'hF);
        end
    endtask

    // Monitor: edge detection on strobes, sampled half a cycle after the active edge.
    logic p_ras = 1'b1, p_casu = 1'b1, p_casl = 1'b1, p_dtack = 1'b1;
    int   ref_cas_cyc = 0;
    int   ras_fall_cyc = 0;
    bit   in_ref = 1'b0;

    always @(negedge CLK_CPU) begin
        if (rst_edge !== 1'b1) begin
            in_ref = 1'b0;
        end else begin
            if (p_ras === 1'b1 && bus.RAS_n === 1'b1 && p_casu === 1'b1 && p_casl === 1'b1 &&
                bus.CASU_n === 1'b0 && bus.CASL_n === 1'b0) begin
                if (ref_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ref_unexpected cyc=%0d required=none", cyc);
                end else begin
                    chk("ref_cas_cyc", cyc, ref_q.pop_front());
                end
                chk("ref_cas_we", bus.WE_n, 1'b1);
                ref_cas_cyc = cyc;
            end
            if (p_ras === 1'b1 && bus.RAS_n === 1'b0) begin
                if (bus.CASU_n === 1'b0 && bus.CASL_n === 1'b0) begin
                    chk("ref_cas_lead", cyc - ref_cas_cyc, 1);
                    chk("ref_ras_we", bus.WE_n, 1'b1);
                    in_ref       = 1'b1;
                    ras_fall_cyc = cyc;
                end else begin
                    pop_acc(KRow);
                end
            end
            if (p_ras === 1'b0 && bus.RAS_n === 1'b1) begin
                if (in_ref) begin
                    chk("ref_ras_width", cyc - ras_fall_cyc, RAS_C);
                    chk("ref_cas_release", {bus.CASU_n, bus.CASL_n}, 2'b11);
                    in_ref = 1'b0;
                end else begin
                    pop_acc(KRel);
                end
            end
            if (p_dtack === 1'b1 && bus.DTACK_DRAM_n === 1'b0) pop_acc(KAck);
        end
        p_ras   = bus.RAS_n;
        p_casu  = bus.CASU_n;
        p_casl  = bus.CASL_n;
        p_dtack = bus.DTACK_DRAM_n;
    end

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge CLK_CPU);
    endtask

    task automatic idle_bus();
        bus.CS_DRAM_n = 1'b1;
        bus.AS_n      = 1'b1;
        bus.UDS_n     = 1'b1;
        bus.LDS_n     = 1'b1;
    endtask

    task automatic req(input logic rw, input logic [19:0] a, input logic u, input logic l);
        bus.ADDR      = a;
        bus.RW        = rw;
        bus.UDS_n     = u;
        bus.LDS_n     = l;
        bus.CS_DRAM_n = 1'b0;
        bus.AS_n      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ras"}, bus.RAS_n, 1'b1);
        chk({tag, "_cas"}, {bus.CASU_n, bus.CASL_n}, 2'b11);
        chk({tag, "_we"}, bus.WE_n, 1'b1);
        chk({tag, "_dtack"}, bus.DTACK_DRAM_n, 1'b1);
        chk({tag, "_ma"}, bus.MA, 10'h000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rl, n, h, n2, n3, n4, w2, n5, w3, r2, n6, r3;
        RST_n       = 1'b0;
        bus.RW      = 1'b1;
        bus.ADDR    = '0;
        idle_bus();
        @(negedge CLK_CPU);
        check_reset("rst_init");
        at_cyc(3);
        RST_n = 1'b1;
        rl    = 3;
        for (int m = 1; m <= 3; m++) ref_q.push_back(rl + m * REF_C + 1);

        // Word read at 0x123456: ADDR 0x91A2B -> row 0x246, column 0x22B.
        at_cyc(rl + 10);
        req(1'b1, 20'h91A2B, 1'b0, 1'b0);
        n = cyc + 1;
        push(KRow, n, 10'h246, 1'b1, 1'b1, 1'b1);
        push(KAck, n + 2, 10'h22B, 1'b0, 1'b0, 1'b1);
        at_cyc(n + 3);
        idle_bus();
        h = n + 4;
        push(KRel, h, 10'h0, 1'b1, 1'b1, 1'b1);

        // Back-to-back byte write, LDS late: waits out precharge, one extra COL cycle.
        at_cyc(h);
        req(1'b0, 20'h556AA, 1'b1, 1'b1);
        n2 = h + PRE_C + 1;
        push(KRow, n2, 10'h155, 1'b1, 1'b1, 1'b1);
        push(KAck, n2 + 3, 10'h2AA, 1'b1, 1'b0, 1'b0);
        at_cyc(n2 + 2);
        bus.LDS_n = 1'b0;
        at_cyc(n2 + 4);
        idle_bus();
        push(KRel, n2 + 5, 10'h0, 1'b1, 1'b1, 1'b1);

        // Abort in ROW, then an upper-byte read after precharge.
        at_cyc(rl + 50);
        req(1'b1, 20'hFFC00, 1'b0, 1'b0);
        n3 = cyc + 1;
        push(KRow, n3, 10'h3FF, 1'b1, 1'b1, 1'b1);
        at_cyc(n3);
        idle_bus();
        push(KRel, n3 + 1, 10'h0, 1'b1, 1'b1, 1'b1);
        at_cyc(n3 + 1);
        req(1'b1, 20'h007FF, 1'b0, 1'b1);
        n4 = n3 + 1 + PRE_C + 1;
        push(KRow, n4, 10'h001, 1'b1, 1'b1, 1'b1);
        push(KAck, n4 + 2, 10'h3FF, 1'b0, 1'b1, 1'b1);
        at_cyc(n4 + 3);
        idle_bus();
        push(KRel, n4 + 4, 10'h0, 1'b1, 1'b1, 1'b1);

        // Request on the second refresh wrap edge: refresh first, row after 3+RAS+PRE.
        w2 = rl + 2 * REF_C;
        at_cyc(w2 - 1);
        req(1'b1, 20'hB0D3C, 1'b0, 1'b0);
        n5 = w2 + 3 + RAS_C + PRE_C;
        push(KRow, n5, 10'h2C3, 1'b1, 1'b1, 1'b1);
        push(KAck, n5 + 2, 10'h13C, 1'b0, 1'b0, 1'b1);
        at_cyc(n5 + 3);
        idle_bus();
        push(KRel, n5 + 4, 10'h0, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of REF_RAS.
        w3 = rl + 3 * REF_C;
        at_cyc(w3 + 2);
        chk("ref_ras_active", bus.RAS_n, 1'b0);
        RST_n = 1'b0;
        at_cyc(w3 + 3);
        check_reset("rst_ref_ras");
        at_cyc(w3 + 4);
        RST_n = 1'b1;
        r2    = w3 + 4;

        // Reset while holding DTACK.
        at_cyc(r2 + 5);
        req(1'b1, 20'h556AA, 1'b0, 1'b0);
        n6 = r2 + 6;
        push(KRow, n6, 10'h155, 1'b1, 1'b1, 1'b1);
        push(KAck, n6 + 2, 10'h2AA, 1'b0, 1'b0, 1'b1);
        at_cyc(n6 + 3);
        chk("hold_dtack", bus.DTACK_DRAM_n, 1'b0);
        RST_n = 1'b0;
        idle_bus();
        at_cyc(n6 + 4);
        check_reset("rst_hold");
        at_cyc(n6 + 5);
        RST_n = 1'b1;
        r3    = n6 + 5;
        ref_q.push_back(r3 + REF_C + 1);

        at_cyc(r3 + REF_C + 10);
        chk("acc_q_drained", acc_q.size(), 0);
        chk("ref_q_drained", ref_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
